// File: rtl/nco_clk_pkg.sv
// Shared types and elaboration-time helpers for the NCO clock-enable generator.
package nco_clk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int     r;
    longint v;
    r = 0;
    v = 64'sd1;
    while (v < longint'(value)) begin
      v = v * 64'sd2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int ch_width(input int n_ch);
    if (n_ch > 1) begin
      return clog2(n_ch);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/nco_clk_en_gen_channel.sv
// One phase-accumulator channel: free-running accumulator with a retunable increment
// and a registered tick that follows the accumulator carry by one cycle.
module nco_channel #(
  parameter int              ACC_W   = 16,
  parameter logic [ACC_W-1:0] INC_RST = ACC_W'(16'h0100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_inc,
  input  logic [ACC_W-1:0] new_inc,
  output logic             carry,
  output logic [ACC_W-1:0] inc_cur,
  output logic             tick,
  output logic [ACC_W-1:0] phase
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum_s;

  // Accumulate with the current increment; the remainder is kept on wrap.
  always_comb begin
    sum_s  = {1'b0, acc_q} + {1'b0, inc_q};
    carry  = en & sum_s[ACC_W];
    tick_d = carry;
    if (en) begin
      acc_d = sum_s[ACC_W-1:0];
    end else begin
      acc_d = acc_q;
    end
    if (load_inc) begin
      inc_d = new_inc;
    end else begin
      inc_d = inc_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      inc_q  <= INC_RST;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      tick_q <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign phase   = acc_q;
  assign inc_cur = inc_q;

endmodule

// File: rtl/nco_clk_en_gen.sv
// Multi-channel NCO clock-enable generator with a single shared retune slot,
// carry-aligned increment updates and a settle/lock indicator.
module nco_clk_en_gen
  import nco_clk_pkg::*;
#(
  parameter int               N_CH        = 2,
  parameter int               ACC_W       = 16,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] INC_RST     = ACC_W'(16'h0100),
  localparam int              CH_W        = ch_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [ACC_W-1:0]      cfg_inc,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH*ACC_W-1:0] phase,
  output logic                  lock
);

  localparam int             CNT_W    = clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
  logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             lock_q, lock_d;

  logic             accept_s;
  logic             apply_s;
  logic [N_CH-1:0]  carry_s;
  logic [N_CH-1:0]  load_s;
  logic [ACC_W-1:0] inc_s [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    nco_channel #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_RST)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[i]),
      .load_inc (load_s[i]),
      .new_inc  (pend_inc_q),
      .carry    (carry_s[i]),
      .inc_cur  (inc_s[i]),
      .tick     (tick[i]),
      .phase    (phase[i*ACC_W +: ACC_W])
    );
  end

  // Retune FSM: accept in IDLE, apply on the target's carry (or at once if it
  // cannot carry), then hold lock low while the settle counter runs.
  always_comb begin
    state_d    = state_q;
    pend_ch_d  = pend_ch_q;
    pend_inc_d = pend_inc_q;
    cnt_d      = cnt_q;
    apply_s    = 1'b0;
    accept_s   = cfg_valid && ready_q;
    case (state_q)
      IDLE: begin
        if (cnt_q != CNT_DONE) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (accept_s && (int'(cfg_ch) < N_CH)) begin
          pend_ch_d  = cfg_ch;
          pend_inc_d = cfg_inc;
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (carry_s[pend_ch_q] || !en[pend_ch_q] || (inc_s[pend_ch_q] == '0)) begin
          apply_s = 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = WAIT;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    for (int i = 0; i < N_CH; i++) begin
      load_s[i] = apply_s && (int'(pend_ch_q) == i);
    end
    ready_d = (state_d == IDLE);
    lock_d  = (state_d == IDLE) && (cnt_d == CNT_DONE);
  end

  // Control state and registered handshake/lock outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_ch_q  <= '0;
      pend_inc_q <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_ch_q  <= pend_ch_d;
      pend_inc_q <= pend_inc_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      lock_q     <= lock_d;
    end
  end

  assign cfg_ready = ready_q;
  assign lock      = lock_q;

endmodule

// File: tb/tb_nco_clk_en_gen.sv
// Directed bench for nco_clk_en_gen: expected tick cycles are queued per channel
// as stimulus is applied and matched against observed ticks.
module tb_nco_clk_en_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_ch;
  logic [15:0] cfg_inc;
  logic [1:0]  tick;
  logic [31:0] phase;
  logic        lock;

  logic [2:0]  en3;
  logic        cfg3_valid;
  logic        cfg3_ready;
  logic [1:0]  cfg3_ch;
  logic [15:0] cfg3_inc;
  logic [2:0]  tick3;
  logic [47:0] phase3;
  logic        lock3;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int q0[$];
  int q1[$];
  int r0;
  int r2;
  int off;

  nco_clk_en_gen #(
    .N_CH(2), .ACC_W(16), .LOCK_CYCLES(16), .INC_RST(16'h4000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .tick(tick), .phase(phase), .lock(lock)
  );

  // Three-channel instance so that an out-of-range channel number is encodable.
  nco_clk_en_gen #(
    .N_CH(3), .ACC_W(16), .LOCK_CYCLES(16), .INC_RST(16'h4000)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready),
    .cfg_ch(cfg3_ch), .cfg_inc(cfg3_inc), .tick(tick3), .phase(phase3), .lock(lock3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ticks(input int ch, input int first, input int step, input int last);
    for (int t = first; t <= last; t += step) begin
      if (ch == 0) q0.push_back(t);
      else q1.push_back(t);
    end
  endtask

  function automatic logic [15:0] p4(input int k);
    return 16'(k * 32'sh4000);
  endfunction

  // Scoreboard: each observed tick must match the next queued cycle.
  always @(negedge clk) begin
    int e;
    if (tick[0]) begin
      e = (q0.size() > 0) ? q0.pop_front() : -1;
      chk("tick0_cycle", 64'(cyc), 64'(e));
    end
    if (tick[1]) begin
      e = (q1.size() > 0) ? q1.pop_front() : -1;
      chk("tick1_cycle", 64'(cyc), 64'(e));
    end
  end

  initial begin
    rst_n = 1'b0; en = 2'b00; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_inc = 16'h0000;
    en3 = 3'b000; cfg3_valid = 1'b0; cfg3_ch = 2'd0; cfg3_inc = 16'h0000;
    repeat (3) tick_clk();
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_lock", 64'(lock), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd0);

    // Release with both channels running at inc 0x4000.
    en = 2'b11; en3 = 3'b001;
    rst_n = 1'b1;
    r0 = cyc;
    push_ticks(0, r0 + 4, 4, r0 + 24);
    push_ticks(0, r0 + 26, 2, r0 + 84);
    push_ticks(1, r0 + 4, 4, r0 + 44);
    push_ticks(1, r0 + 58, 4, r0 + 58);
    for (int k = 0; k < 20; k++) begin
      chk("settle_lock", 64'(lock), 64'(k >= 16));
      chk("settle_ready", 64'(cfg_ready), 64'(k >= 1));
      chk("settle_phase0", 64'(phase[15:0]), 64'(p4(k)));
      tick_clk();
    end

    // Retune ch0 to 0x8000 mid-period.
    tick_clk();
    chk("pre_cfg_ready", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 16'h8000;
    tick_clk();
    cfg_valid = 1'b0;
    chk("wait_ready", 64'(cfg_ready), 64'd0);
    chk("wait_lock", 64'(lock), 64'd0);
    while (cyc < r0 + 44) begin
      tick_clk();
      off = cyc - r0;
      chk("retune_lock", 64'(lock), 64'(off >= 40));
      chk("retune_ready", 64'(cfg_ready), 64'(off >= 40));
      chk("retune_phase0", 64'(phase[15:0]),
          64'((off >= 24) ? (((off % 2) == 1) ? 16'h8000 : 16'h0000) : p4(off)));
    end

    // Pause ch1 for 10 cycles.
    tick_clk();
    en = 2'b01;
    for (int k = 0; k < 10; k++) begin
      tick_clk();
      chk("pause_phase1", 64'(phase[31:16]), 64'h4000);
      chk("pause_tick1", 64'(tick[1]), 64'd0);
    end
    en = 2'b11;
    repeat (5) tick_clk();
    chk("resume_phase1", 64'(phase[31:16]), 64'h8000);

    // Retune disabled ch1 to inc 0.
    en = 2'b01; cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 16'h0000;
    tick_clk();
    cfg_valid = 1'b0;
    chk("zero_wait_ready", 64'(cfg_ready), 64'd0);
    tick_clk();
    chk("zero_apply_lock", 64'(lock), 64'd0);
    repeat (2) tick_clk();
    en = 2'b11;
    while (cyc < r0 + 80) begin
      tick_clk();
      off = cyc - r0;
      chk("zero_lock", 64'(lock), 64'(off >= 78));
      chk("zero_phase1", 64'(phase[31:16]), 64'h8000);
    end

    // Out-of-range channel on the three-channel instance.
    chk("oor_pre_lock", 64'(lock3), 64'd1);
    cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_inc = 16'h1234;
    tick_clk();
    cfg3_valid = 1'b0;
    chk("oor_ready", 64'(cfg3_ready), 64'd1);
    chk("oor_lock", 64'(lock3), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick_clk();
      chk("oor_phase0", 64'(phase3[15:0]), 64'(p4(cyc - r0)));
      chk("oor_lock_hold", 64'(lock3), 64'd1);
    end

    // Reset while a ch0 retune is pending.
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 16'h2000;
    tick_clk();
    cfg_valid = 1'b0;
    chk("pend_ready", 64'(cfg_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tick", 64'(tick), 64'd0);
    chk("mid_rst_phase", 64'(phase), 64'd0);
    chk("mid_rst_lock", 64'(lock), 64'd0);
    chk("mid_rst_ready", 64'(cfg_ready), 64'd0);
    chk("mid_rst_lock3", 64'(lock3), 64'd0);
    repeat (3) tick_clk();
    rst_n = 1'b1;
    r2 = cyc;
    push_ticks(0, r2 + 4, 4, r2 + 20);
    push_ticks(1, r2 + 4, 4, r2 + 20);
    for (int k = 0; k < 22; k++) begin
      chk("rerst_lock", 64'(lock), 64'(k >= 16));
      chk("rerst_phase0", 64'(phase[15:0]), 64'(p4(k)));
      chk("rerst_phase1", 64'(phase[31:16]), 64'(p4(k)));
      tick_clk();
    end
    chk("tick0_missing", 64'(q0.size()), 64'd0);
    chk("tick1_missing", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
